full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder.sv | 51 +++++
 tb/tb_full_adder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with combinational Sum/Cout and a registered
// snapshot of Sum, Cout and signed overflow, captured under en.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             en,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q,
  output logic             ovf_q,
  output logic             valid_q
);

  logic [WIDTH:0] carry;
  logic           ovf;

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out
  always_comb begin
    carry    = '0;
    Sum      = '0;
    carry[0] = Cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      Sum[i]     = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = carry[WIDTH];
  assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q   <= '0;
      Cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      Sum_q   <= Sum;
      Cout_q  <= Cout;
      ovf_q   <= ovf;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 and a WIDTH=4 instance share clock,
// reset and enable; expected values are hand-computed constants.
module tb_full_adder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a1, b1, c1;
  logic       sum1, cout1, sum_q1, cout_q1, ovf_q1, valid_q1;
  logic [3:0] a4, b4;
  logic       c4;
  logic [3:0] sum4, sum_q4;
  logic       cout4, cout_q4, ovf_q4, valid_q4;

  int n_cmp = 0;
  int n_err = 0;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .en(en),
    .Sum(sum1), .Cout(cout1), .Sum_q(sum_q1), .Cout_q(cout_q1),
    .ovf_q(ovf_q1), .valid_q(valid_q1)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .en(en),
    .Sum(sum4), .Cout(cout4), .Sum_q(sum_q4), .Cout_q(cout_q4),
    .ovf_q(ovf_q4), .valid_q(valid_q4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {Sum,Cout} for {A,B,Cin} = 0..7
  logic [7:0] exp_sum1  = 8'b1001_0110;
  logic [7:0] exp_cout1 = 8'b1110_1000;

  initial begin
    rst = 1'b1; en = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    a4 = 4'h3; b4 = 4'h2; c4 = 1'b0;

    // Reset: registers clear, combinational path keeps working
    tick();
    check("rst_sum_q1",   32'(sum_q1),   32'd0);
    check("rst_cout_q1",  32'(cout_q1),  32'd0);
    check("rst_ovf_q1",   32'(ovf_q1),   32'd0);
    check("rst_valid_q1", 32'(valid_q1), 32'd0);
    check("rst_sum_q4",   32'(sum_q4),   32'd0);
    check("rst_valid_q4", 32'(valid_q4), 32'd0);
    check("rst_comb_sum1",  32'(sum1),  32'd0);
    check("rst_comb_cout1", 32'(cout1), 32'd1);
    check("rst_comb_sum4",  32'(sum4),  32'd5);

    // WIDTH=1 exhaustive truth table, 10 ns per vector, no capture
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      {a1, b1, c1} = 3'(v);
      #1;
      check($sformatf("tt_sum_%0d", v),  32'(sum1),  32'(exp_sum1[v]));
      check($sformatf("tt_cout_%0d", v), 32'(cout1), 32'(exp_cout1[v]));
      #9;
    end
    tick();
    check("no_en_valid_q1", 32'(valid_q1), 32'd0);

    // Capture 1+1+1
    @(negedge clk);
    {a1, b1, c1} = 3'b111; en = 1'b1;
    tick();
    check("cap_sum_q1",   32'(sum_q1),   32'd1);
    check("cap_cout_q1",  32'(cout_q1),  32'd1);
    check("cap_ovf_q1",   32'(ovf_q1),   32'd0);
    check("cap_valid_q1", 32'(valid_q1), 32'd1);

    // Hold with en low while inputs change
    @(negedge clk);
    en = 1'b0; {a1, b1, c1} = 3'b000;
    tick();
    check("hold_sum_q1",   32'(sum_q1),   32'd1);
    check("hold_cout_q1",  32'(cout_q1),  32'd1);
    check("hold_valid_q1", 32'(valid_q1), 32'd1);
    check("hold_comb_sum1", 32'(sum1),    32'd0);

    // WIDTH=4 carry wrap
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; en = 1'b1;
    #1;
    check("wrap_sum4",  32'(sum4),  32'h0);
    check("wrap_cout4", 32'(cout4), 32'd1);
    tick();
    check("wrap_sum_q4",  32'(sum_q4),  32'h0);
    check("wrap_cout_q4", 32'(cout_q4), 32'd1);
    check("wrap_ovf_q4",  32'(ovf_q4),  32'd0);
    check("wrap_valid_q4", 32'(valid_q4), 32'd1);

    // WIDTH=4 signed overflow
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
    #1;
    check("sovf_sum4",  32'(sum4),  32'h8);
    check("sovf_cout4", 32'(cout4), 32'd0);
    tick();
    check("sovf_sum_q4", 32'(sum_q4), 32'h8);
    check("sovf_ovf_q4", 32'(ovf_q4), 32'd1);

    // -1 + -1 + 1 = -1: carry out without signed overflow
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    check("neg_sum_q4",  32'(sum_q4),  32'hF);
    check("neg_cout_q4", 32'(cout_q4), 32'd1);
    check("neg_ovf_q4",  32'(ovf_q4),  32'd0);

    // Reset beats enable; combinational outputs still track inputs
    @(negedge clk);
    a4 = 4'h5; b4 = 4'h6; c4 = 1'b0; rst = 1'b1; en = 1'b1;
    tick();
    check("prio_sum_q4",   32'(sum_q4),   32'd0);
    check("prio_cout_q4",  32'(cout_q4),  32'd0);
    check("prio_ovf_q4",   32'(ovf_q4),   32'd0);
    check("prio_valid_q4", 32'(valid_q4), 32'd0);
    check("prio_valid_q1", 32'(valid_q1), 32'd0);
    check("prio_comb_sum4", 32'(sum4),    32'hB);

    // valid_q stays low until the next capture
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    tick();
    check("post_rst_valid_q4", 32'(valid_q4), 32'd0);

    // Capture 3+4+1 (signed overflow), then reset mid-operation
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b1; en = 1'b1;
    tick();
    check("mid_sum_q4", 32'(sum_q4), 32'h8);
    check("mid_ovf_q4", 32'(ovf_q4), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid_rst_sum_q4",   32'(sum_q4),   32'd0);
    check("mid_rst_ovf_q4",   32'(ovf_q4),   32'd0);
    check("mid_rst_valid_q4", 32'(valid_q4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
